mdu_ctrl: RTL and testbench

//   Multiply/divide unit controller for the E stage. Accepts mult/multu/div/divu, mthi and mtlo from the
//   D/E register outputs, and owns the HI/LO registers and the busy sequencing. Supplies mfhi/mflo read data.

---
 rtl/mips_defs.sv | 36 +++
 rtl/mdu_ctrl_if.sv | 30 +++
 rtl/mdu_ctrl.sv | 88 ++++++++
 tb/tb_mdu_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// mips_defs: shared MDU opcode encodings, FSM state type, default latencies and arithmetic helpers
package mips_defs;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} md_state_t;

    // Full 64-bit product; signed operands are sign-extended so one unsigned multiply covers both.
    function automatic logic [63:0] md_multiply(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [63:0] ax, bx;
        ax = {sgn ? {32{a[31]}} : 32'h0, a};
        bx = {sgn ? {32{b[31]}} : 32'h0, b};
        return ax * bx;
    endfunction

    // {rem, quot}: divides magnitudes, then fixes signs (quotient toward zero, remainder follows dividend).
    // The magnitude path also yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
    function automatic logic [63:0] md_divide(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic        neg_r, neg_q;
        logic [31:0] ma, mb, q, r;
        neg_r = sgn & a[31];
        neg_q = sgn & (a[31] ^ b[31]);
        ma    = neg_r ? -a : a;
        mb    = (sgn & b[31]) ? -b : b;
        q     = (mb == 32'h0) ? 32'h0 : ma / mb;
        r     = (mb == 32'h0) ? 32'h0 : ma % mb;
        return (b == 32'h0) ? {a, 32'hFFFF_FFFF} : {neg_r ? -r : r, neg_q ? -q : q};
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E-stage multiply/divide request, HI/LO access and stall signals
interface mdu_ctrl_if;

    logic        Req;
    logic        Start_E;
    logic [1:0]  MDOp_E;
    logic [31:0] A_E;
    logic [31:0] B_E;
    logic        HIWrite_E;
    logic        LOWrite_E;
    logic        HIRead_E;
    logic        LORead_E;
    logic        MDUse_D;
    logic        Busy;
    logic        MDStall;
    logic [31:0] MDOut;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Req, Start_E, MDOp_E, A_E, B_E, HIWrite_E, LOWrite_E, HIRead_E, LORead_E, MDUse_D,
        input  Busy, MDStall, MDOut, HI, LO
    );

    modport slave (
        input  Req, Start_E, MDOp_E, A_E, B_E, HIWrite_E, LOWrite_E, HIRead_E, LORead_E, MDUse_D,
        output Busy, MDStall, MDOut, HI, LO
    );

endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: owns HI/LO, sequences fixed-latency mult/div and raises the D-stage stall
module mdu_ctrl
    import mips_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);

    localparam logic [3:0] MUL_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD = 4'(DIV_CYCLES);

    md_state_t   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi, pend_lo, hi_q, lo_q;
    logic        accept, commit, idle, is_div, sgn;
    logic [63:0] res;

    assign idle   = (state_q == S_IDLE);
    assign is_div = (bus.MDOp_E == MD_DIV) | (bus.MDOp_E == MD_DIVU);
    assign sgn    = (bus.MDOp_E == MD_MULT) | (bus.MDOp_E == MD_DIV);
    assign res    = is_div ? md_divide(bus.A_E, bus.B_E, sgn) : md_multiply(bus.A_E, bus.B_E, sgn);

    assign bus.Busy    = ~idle;
    assign bus.MDStall = bus.MDUse_D & (~idle | bus.Start_E);
    assign bus.MDOut   = bus.HIRead_E ? hi_q : bus.LORead_E ? lo_q : 32'h0;
    assign bus.HI      = hi_q;
    assign bus.LO      = lo_q;

    // Next state: accept a start in IDLE, otherwise count down and commit on the last busy cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        if (idle) begin
            accept = bus.Start_E & ~bus.Req;
            if (accept) begin
                state_d = is_div ? S_DIV : S_MUL;
                cnt_d   = is_div ? DIV_LD : MUL_LD;
            end
        end else begin
            cnt_d  = cnt_q - 4'd1;
            commit = (cnt_q == 4'd1);
            if (commit) state_d = S_IDLE;
        end
    end

    // State register and busy countdown
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The whole result is computed at issue and held here, invisible until commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_hi <= 32'h0;
            pend_lo <= 32'h0;
        end else if (accept) begin
            pend_hi <= res[63:32];
            pend_lo <= res[31:0];
        end
    end

    // Architectural HI/LO: commit of a finished op, or direct mthi/mtlo when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= 32'h0;
            lo_q <= 32'h0;
        end else if (commit) begin
            hi_q <= pend_hi;
            lo_q <= pend_lo;
        end else if (idle & ~bus.Req) begin
            if (bus.HIWrite_E) hi_q <= bus.A_E;
            if (bus.LOWrite_E) lo_q <= bus.A_E;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vectors with a commit/read scoreboard checked by a negedge monitor
module tb_mdu_ctrl;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [31:0] rd_q[$];
    logic prev_busy = 1'b0;
    int   busy_cnt = 0;

    mdu_ctrl_if bus();

    mdu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: on each busy->idle transition pop the expected commit; on each read pop the expected MDOut
    always @(negedge clk) begin
        if (bus.Busy && (bus.Start_E || bus.HIWrite_E || bus.LOWrite_E))
            $error("protocol: request while busy");
        if (reset) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (bus.Busy) begin
                busy_cnt++;
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_commit", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("commit_hi", bus.HI, e.hi);
                    chk("commit_lo", bus.LO, e.lo);
                    chk("busy_cycles", 32'(busy_cnt), 32'(e.n));
                end
                busy_cnt = 0;
            end
            prev_busy = bus.Busy;
            if (bus.HIRead_E || bus.LORead_E) begin
                if (rd_q.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
                else chk("mdout", bus.MDOut, rd_q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        bit done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (!bus.Busy) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input int n);
        bus.Start_E = 1'b1;
        bus.MDOp_E  = op;
        bus.A_E     = a;
        bus.B_E     = b;
        exp_q.push_back('{hi, lo, n});
        @(posedge clk);
        #1;
        bus.Start_E = 1'b0;
        wait_idle();
    endtask

    initial begin
        bit seen_busy;
        bus.Req = 0; bus.Start_E = 0; bus.MDOp_E = 0; bus.A_E = 0; bus.B_E = 0;
        bus.HIWrite_E = 0; bus.LOWrite_E = 0; bus.HIRead_E = 0; bus.LORead_E = 0; bus.MDUse_D = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(bus.Busy), 32'd0);
        chk("reset_stall", 32'(bus.MDStall), 32'd0);
        chk("reset_hi", bus.HI, 32'h0);
        chk("reset_lo", bus.LO, 32'h0);
        chk("reset_mdout", bus.MDOut, 32'h0);
        @(posedge clk);
        #1;

        issue(2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(2'b01, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(2'b11, 32'd7,         32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 10);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);
        issue(2'b10, 32'd7,         32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 10);
        issue(2'b11, 32'd100,       32'd7, 32'h2, 32'hE, 10);
        issue(2'b10, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 10);

        // Stall during an in-flight mult, including the issue cycle
        bus.MDUse_D = 1'b1;
        bus.Start_E = 1'b1; bus.MDOp_E = 2'b00; bus.A_E = 32'h0001_0000; bus.B_E = 32'h0001_0000;
        exp_q.push_back('{32'h1, 32'h0, 5});
        @(negedge clk);
        chk("stall_issue", 32'(bus.MDStall), 32'd1);
        @(posedge clk);
        #1 bus.Start_E = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_busy", 32'(bus.MDStall), 32'd1);
        end
        @(negedge clk);
        chk("stall_release", 32'(bus.MDStall), 32'd0);
        @(posedge clk);
        #1 bus.MDUse_D = 1'b0;

        // Flushed start and flushed mthi are ignored
        bus.Req = 1'b1; bus.Start_E = 1'b1; bus.MDOp_E = 2'b00; bus.A_E = 32'd5; bus.B_E = 32'd5;
        @(posedge clk);
        #1 bus.Start_E = 1'b0; bus.HIWrite_E = 1'b1; bus.A_E = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("req_start_busy", 32'(bus.Busy), 32'd0);
        @(posedge clk);
        #1 bus.HIWrite_E = 1'b0; bus.Req = 1'b0;
        @(negedge clk);
        chk("req_busy", 32'(bus.Busy), 32'd0);
        chk("req_hi", bus.HI, 32'h1);
        chk("req_lo", bus.LO, 32'h0);
        @(posedge clk);
        #1;

        // Req during a running div does not cancel it
        bus.Start_E = 1'b1; bus.MDOp_E = 2'b10; bus.A_E = 32'd20; bus.B_E = 32'd3;
        exp_q.push_back('{32'h2, 32'h6, 10});
        @(posedge clk);
        #1 bus.Start_E = 1'b0;
        @(posedge clk);
        #1 bus.Req = 1'b1;
        @(posedge clk);
        #1 bus.Req = 1'b0;
        wait_idle();

        // mthi/mtlo then reads
        bus.HIWrite_E = 1'b1; bus.A_E = 32'h1234_5678;
        @(posedge clk);
        #1 bus.HIWrite_E = 1'b0; bus.HIRead_E = 1'b1; rd_q.push_back(32'h1234_5678);
        @(posedge clk);
        #1 bus.HIRead_E = 1'b0; bus.LORead_E = 1'b1; rd_q.push_back(32'h6);
        @(posedge clk);
        #1 bus.LORead_E = 1'b0; bus.LOWrite_E = 1'b1; bus.A_E = 32'hCAFE_BABE;
        @(posedge clk);
        #1 bus.LOWrite_E = 1'b0; bus.LORead_E = 1'b1; rd_q.push_back(32'hCAFE_BABE);
        @(posedge clk);
        #1 bus.LORead_E = 1'b0; bus.HIRead_E = 1'b1; rd_q.push_back(32'h1234_5678);
        @(posedge clk);
        #1 bus.HIRead_E = 1'b0;
        @(negedge clk);
        chk("mdout_noread", bus.MDOut, 32'h0);
        @(posedge clk);
        #1;

        // Async reset in the middle of a mult
        bus.Start_E = 1'b1; bus.MDOp_E = 2'b00; bus.A_E = 32'd3; bus.B_E = 32'd4;
        @(posedge clk);
        #1 bus.Start_E = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(bus.Busy), 32'd0);
        chk("rst_mid_hi", bus.HI, 32'h0);
        chk("rst_mid_lo", bus.LO, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        seen_busy = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.Busy) seen_busy = 1'b1;
        end
        chk("rst_no_busy", 32'(seen_busy), 32'd0);
        chk("rst_no_commit_hi", bus.HI, 32'h0);
        chk("rst_no_commit_lo", bus.LO, 32'h0);

        chk("commits_left", 32'(exp_q.size()), 32'd0);
        chk("reads_left", 32'(rd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
